ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 21 ++
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host transmit shared types and constants.
// Holds the FSM state enum, frame sizes and a us-to-cycles helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam int unsigned FRAME_EDGES = 11;
  localparam int unsigned DATA_BITS   = 8;

  function automatic int unsigned us_to_cycles(
    input int unsigned hz,
    input int unsigned us
  );
    return (hz / 1000000) * us;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 line plus a falling-edge pulse.
// Flops reset high because an idle PS/2 line floats high.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic [2:0] r_sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sh <= '1;
    else        r_sh <= {r_sh[1:0], i_line};
  end

  assign o_level = r_sh[1];
  assign o_fall  = r_sh[2] & ~r_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, RTS, 11-edge frame, ACK).
// Define PS2_TX_TIMEOUT_EN to add the per-edge watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_CYC =
    us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC =
    us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned CNT_MAX =
    (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
  localparam int TW = $clog2(CNT_MAX + 1);
  // RTS holds the clock low one more cycle, so INHIBIT ends early
  localparam logic [TW-1:0] INH_LAST = TW'(INH_CYC - 2);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
`endif

  state_t          r_state;
  logic [TW-1:0]   r_cnt;
  logic [3:0]      r_edges;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [1:0]      r_dsync;
  logic            w_clk_lvl;
  logic            w_clk_fall;
  logic            w_data_lvl;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .reset   (reset),
    .i_line  (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  assign w_data_lvl = r_dsync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_edges     <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_dsync     <= '1;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      r_dsync  <= {r_dsync[0], ps2_data_in};
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            r_shift    <= tx_data;
            r_par      <= ~^tx_data;
            r_cnt      <= '0;
            ps2_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            r_state    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_cnt == INH_LAST) begin
            r_cnt       <= '0;
            ps2_data_oe <= 1'b1;
            r_state     <= ST_RTS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RTS: begin
          ps2_clk_oe <= 1'b0;
          r_edges    <= '0;
          r_state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_clk_fall) begin
            r_edges <= r_edges + 1'b1;
            if (r_edges < 4'(DATA_BITS)) begin
              ps2_data_oe <= ~r_shift[0];
              r_shift     <= r_shift >> 1;
            end else if (r_edges == 4'(DATA_BITS)) begin
              ps2_data_oe <= ~r_par;
            end else begin
              ps2_data_oe <= 1'b0;
              r_state     <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (w_clk_fall) begin
            r_edges <= 4'(FRAME_EDGES);
            if (w_data_lvl) begin
              tx_error <= 1'b1;
              tx_ready <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_lvl && w_data_lvl) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog restarts on every device clock edge
      if (r_state inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
        if (w_clk_fall) begin
          r_cnt <= '0;
        end else if (r_cnt == TO_LAST) begin
          r_cnt       <= '0;
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_done     <= 1'b0;
          tx_error    <= 1'b1;
          tx_ready    <= 1'b1;
          r_state     <= ST_IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
// Open-drain lines are modelled as device level AND NOT host pull-down.
module tb_ps2_host_tx;

  localparam int INH    = 10000;
  localparam int HALF   = 20;
  localparam int TO_US  = 20;
  localparam int TO_CYC = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int failures = 0;
  int n_done_tot = 0;
  int n_err_tot = 0;
  int n_co_tot = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ (100000000),
    .INHIBIT_US  (100),
    .TIMEOUT_US  (TO_US)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always @(negedge clk) begin
    if (tx_done) n_done_tot++;
    if (tx_error) n_err_tot++;
    if (tx_done && tx_error) n_co_tot++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic frame(
    input logic [7:0] b,
    input logic       ack,
    input int         abort_e,
    input bit         dup
  );
    int n_clk, n_both, d0, e0, c0;
    logic [9:0] seen;
    bit ok;
    ok = 1'b0;
    seen = '0;
    d0 = n_done_tot;
    e0 = n_err_tot;
    c0 = n_co_tot;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = tx_ready;
    end
    check("ready_idle", 32'(ok), 1);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    check("ready_drop", 32'(tx_ready), 0);
    if (dup) tx_data = 8'h55;
    else tx_valid = 1'b0;
    n_clk = 0;
    n_both = 0;
    for (int i = 0; i < INH + 100; i++) begin
      if (i > 0) @(negedge clk);
      if (dup && i == 50) tx_valid = 1'b0;
      if (!ps2_clk_oe) break;
      n_clk++;
      if (ps2_data_oe) n_both++;
    end
    check("inhibit_len", n_clk, INH);
    check("rts_overlap", n_both, 1);
    check("start_bit", 32'(ps2_data_in), 0);
    repeat (HALF) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) seen = {ps2_data_in, seen[9:1]};
      if (e == 10) dev_data = ack;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e == abort_e) return;
    end
    dev_data = 1'b1;
    check("frame_bits", 32'(seen), 32'({1'b1, ~^b, b}));
    repeat (200) @(negedge clk);
    check("done_pulses", n_done_tot - d0, ack ? 0 : 1);
    check("err_pulses", n_err_tot - e0, ack ? 1 : 0);
    check("done_err_same", n_co_tot - c0, 0);
    check("ready_back", 32'(tx_ready), 1);
    check("oe_idle", 32'({ps2_clk_oe, ps2_data_oe}), 0);
  endtask

  initial begin
    int n_extra;
    int d0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_error", 32'(tx_error), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    frame(8'hED, 1'b0, 0, 1'b1);
    n_extra = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) n_extra++;
    end
    check("no_second_frame", n_extra, 0);

    frame(8'h00, 1'b0, 0, 1'b0);
    frame(8'hFF, 1'b0, 0, 1'b0);
    frame(8'h01, 1'b1, 0, 1'b0);

    d0 = n_done_tot;
    frame(8'hAA, 1'b0, 5, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    check("rst_mid_ready", 32'(tx_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("rst_mid_no_done", n_done_tot - d0, 0);
    frame(8'hF4, 1'b0, 0, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      bit seen_rts;
      tx_data = 8'h12;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      seen_rts = 1'b0;
      for (int i = 0; i < INH + 100 && !seen_rts; i++) begin
        @(negedge clk);
        seen_rts = ps2_data_oe;
      end
      check("to_rts_seen", 32'(seen_rts), 1);
      n = 0;
      for (int i = 0; i < TO_CYC + 100; i++) begin
        @(negedge clk);
        n++;
        if (tx_error) break;
      end
      check("to_latency", n, TO_CYC);
      check("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
      repeat (5) @(negedge clk);
      check("to_ready", 32'(tx_ready), 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
